i2c_txn_arbiter: RTL

//  Round-robin arbiter/sequencer sharing the single i2c read/write engine top among NREQ requesters.

---
 rtl/i2c_pkg.sv | 6 +
 rtl/i2c_txn_arbiter_if.sv | 18 +
 rtl/i2c_rr_pick.sv | 21 ++
 rtl/i2c_txn_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and word widths for the i2c transaction arbiter
package i2c_pkg;
  localparam int I2C_WORD_W = 32;
  localparam int I2C_BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if: requester handshake plus i2c engine bus
// master = arbiter side, slave = requesters/engine side.
interface i2c_txn_arbiter_if import i2c_pkg::*; #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_valid, req_rw, req_ready, rsp_valid;
  logic [NREQ*I2C_WORD_W-1:0] req_data;
  logic rsp_ack, rsp_err, arb_busy, rw, startread, startwrite;
  logic busyR, busyW, doneR, doneW, ack;
  logic [I2C_BYTE_W-1:0] rsp_data, i2c_data_out;
  logic [I2C_WORD_W-1:0] i2c_data;
  modport master (
    input  req_valid, req_rw, req_data, busyR, busyW, doneR, doneW, ack, i2c_data_out,
    output req_ready, rsp_valid, rsp_ack, rsp_data, rsp_err, arb_busy, rw, startread, startwrite, i2c_data
  );
  modport slave (
    output req_valid, req_rw, req_data, busyR, busyW, doneR, doneW, ack, i2c_data_out,
    input  req_ready, rsp_valid, rsp_ack, rsp_data, rsp_err, arb_busy, rw, startread, startwrite, i2c_data
  );
endinterface

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: combinational round-robin picker, first request after ptr_i wins
// req_i -> gnt_o (one-hot), idx_o (index), any_o.
module i2c_rr_pick #(parameter int NREQ = 2) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);
  logic [$clog2(NREQ)-1:0] j;
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = $clog2(NREQ)'((int'(ptr_i) + k) % NREQ);
      if (req_i[j]) idx_o = j;
    end
    any_o = |req_i;
    gnt_o = any_o ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sequencer sharing one i2c read/write engine among NREQ requesters
// Ports: clk, reset (sync, active-high), bus (i2c_txn_arbiter_if.master: requester handshake + engine controls).
// Optional I2C_TIMEOUT_EN: abort a transaction after TIMEOUT_CYC cycles in START/WAIT with rsp_err=1.
module i2c_txn_arbiter import i2c_pkg::*; #(
  parameter int NREQ = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic reset,
  i2c_txn_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  state_t state_q;
  logic [IW-1:0] ptr_q, idx;
  logic [NREQ-1:0] gnt, req_ready_q, rsp_valid_q;
  logic any, rsp_ack_q, rsp_err_q, rw_q, startread_q, startwrite_q;
  logic [I2C_BYTE_W-1:0] rsp_data_q;
  logic [I2C_WORD_W-1:0] i2c_data_q;
  logic [1:0] br_q, bw_q;
  logic busy_sel, ok, tmo, fin, unused_done;
  i2c_rr_pick #(.NREQ(NREQ)) u_pick (.req_i(bus.req_valid), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(idx), .any_o(any));
  always_ff @(posedge clk) begin
    br_q <= reset ? 2'b00 : {br_q[0], bus.busyR};
    bw_q <= reset ? 2'b00 : {bw_q[0], bus.busyW};
  end
  assign busy_sel = rw_q ? br_q[1] : bw_q[1];
  assign ok = state_q == WAIT && !busy_sel;
  assign fin = ok || tmo;
  assign unused_done = bus.doneR ^ bus.doneW;
`ifdef I2C_TIMEOUT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (reset || state_q == IDLE || state_q == RESP) ? 16'd0 : cnt_q + 16'd1;
  assign tmo = cnt_q == 16'(TIMEOUT_CYC - 1);
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYC);
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= IW'(NREQ - 1);
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_ack_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      rw_q <= 1'b0;
      startread_q <= 1'b0;
      startwrite_q <= 1'b0;
      i2c_data_q <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: if (any) begin
          req_ready_q <= gnt;
          ptr_q <= idx;
          rw_q <= bus.req_rw[idx];
          startread_q <= bus.req_rw[idx];
          startwrite_q <= ~bus.req_rw[idx];
          i2c_data_q <= bus.req_data[idx*I2C_WORD_W +: I2C_WORD_W];
          state_q <= START;
        end
        START, WAIT: if (state_q == START && busy_sel) begin
          startread_q <= 1'b0;
          startwrite_q <= 1'b0;
          state_q <= WAIT;
        end else if (fin) begin
          startread_q <= 1'b0;
          startwrite_q <= 1'b0;
          rsp_valid_q <= NREQ'(1) << ptr_q;
          rsp_ack_q <= ok & bus.ack;
          rsp_data_q <= (ok && rw_q) ? bus.i2c_data_out : '0;
          rsp_err_q <= ~ok;
          state_q <= RESP;
        end
        default: begin
          rsp_ack_q <= 1'b0;
          rsp_data_q <= '0;
          rsp_err_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ack = rsp_ack_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.arb_busy = state_q != IDLE;
  assign bus.rw = rw_q;
  assign bus.startread = startread_q;
  assign bus.startwrite = startwrite_q;
  assign bus.i2c_data = i2c_data_q;
endmodule
